// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one slave bus between two masters (M0 = ibus,
// M1 = dbus) with breq/bgnt handshake, round-robin tie-break, burst limit
// while the other master waits, region decode and decode-miss bus errors.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a slave response timeout
// that terminates a stalled transaction with berror.
module mem_bus_arbiter #(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter logic [3:0] REGION      = 4'hF,
  parameter int         MAX_BURST   = 4,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_breq,
  output logic              m0_bgnt,
  input  logic              m0_bstart,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wr,
  input  logic [1:0]        m0_tsize,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_bdone,
  output logic              m0_berror,
  input  logic              m1_breq,
  output logic              m1_bgnt,
  input  logic              m1_bstart,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wr,
  input  logic [1:0]        m1_tsize,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_bdone,
  output logic              m1_berror,
  output logic              s_ss,
  output logic              s_bstart,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wr,
  output logic [1:0]        s_tsize,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_bdone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYC - 1);

  state_t              state_r;
  logic                owner_r;       // 0 = M0, 1 = M1
  logic                last_owner_r;
  logic [1:0]          bgnt_r;
  logic [1:0]          miss_err_r;
  logic [3:0]          burst_cnt_r;
  logic [ADDR_W-1:0]   lat_addr_r;
  logic [DATA_W-1:0]   lat_wdata_r;
  logic                lat_wr_r;
  logic [1:0]          lat_tsize_r;

  logic                own_breq_s;
  logic                other_breq_s;
  logic                own_bstart_s;
  logic [ADDR_W-1:0]   own_addr_s;
  logic [DATA_W-1:0]   own_wdata_s;
  logic                own_wr_s;
  logic [1:0]          own_tsize_s;
  logic                hit_s;
  logic                start_hit_s;
  logic                done_s;
  logic                timeout_s;
  logic [3:0]          burst_next_s;
  logic                pick_s;

  // Route the current owner's request signals onto common nets.
  always_comb begin
    own_breq_s   = 1'b0;
    other_breq_s = 1'b0;
    own_bstart_s = 1'b0;
    own_addr_s   = '0;
    own_wdata_s  = '0;
    own_wr_s     = 1'b0;
    own_tsize_s  = 2'd0;
    if (owner_r) begin
      own_breq_s   = m1_breq;
      other_breq_s = m0_breq;
      own_bstart_s = m1_bstart;
      own_addr_s   = m1_addr;
      own_wdata_s  = m1_wdata;
      own_wr_s     = m1_wr;
      own_tsize_s  = m1_tsize;
    end else begin
      own_breq_s   = m0_breq;
      other_breq_s = m1_breq;
      own_bstart_s = m0_bstart;
      own_addr_s   = m0_addr;
      own_wdata_s  = m0_wdata;
      own_wr_s     = m0_wr;
      own_tsize_s  = m0_tsize;
    end
  end

  assign hit_s        = (own_addr_s[ADDR_W-1 -: 4] == REGION);
  assign start_hit_s  = (state_r == ST_GRANT) && own_bstart_s && hit_s;
  assign done_s       = (state_r == ST_BUSY) && s_bdone;
  assign burst_next_s = (burst_cnt_r == BURST_MAX) ? burst_cnt_r : (burst_cnt_r + 4'd1);
  // Both requesting: the master that did not own the bus last wins.
  assign pick_s       = (m0_breq && m1_breq) ? ~last_owner_r : m1_breq;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] to_cnt_r;

  // Cycles spent waiting in BUSY; cleared when a transaction is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= 8'd0;
    end else if (start_hit_s) begin
      to_cnt_r <= 8'd0;
    end else if (state_r == ST_BUSY) begin
      to_cnt_r <= to_cnt_r + 8'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // A slave completion in the same cycle takes priority over the timeout.
  assign timeout_s = (state_r == ST_BUSY) && !s_bdone && (to_cnt_r == TO_LAST);
`else
  logic unused_to_s;
  assign unused_to_s = ^TO_LAST;
  assign timeout_s   = 1'b0;
`endif

  // Arbitration FSM: ownership, grants, burst accounting and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      bgnt_r       <= 2'b00;
      miss_err_r   <= 2'b00;
      burst_cnt_r  <= 4'd0;
      lat_addr_r   <= '0;
      lat_wdata_r  <= '0;
      lat_wr_r     <= 1'b0;
      lat_tsize_r  <= 2'd0;
    end else begin
      miss_err_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (m0_breq || m1_breq) begin
            owner_r     <= pick_s;
            bgnt_r      <= pick_s ? 2'b10 : 2'b01;
            burst_cnt_r <= 4'd0;
            state_r     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (own_bstart_s) begin
            if (hit_s) begin
              lat_addr_r  <= own_addr_s;
              lat_wdata_r <= own_wdata_s;
              lat_wr_r    <= own_wr_s;
              lat_tsize_r <= own_tsize_s;
              state_r     <= ST_BUSY;
            end else begin
              miss_err_r <= owner_r ? 2'b10 : 2'b01;
            end
          end else if (!own_breq_s) begin
            bgnt_r       <= 2'b00;
            last_owner_r <= owner_r;
            state_r      <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (s_bdone) begin
            burst_cnt_r <= burst_next_s;
            if (other_breq_s && (burst_next_s == BURST_MAX)) begin
              bgnt_r       <= 2'b00;
              last_owner_r <= owner_r;
              state_r      <= ST_IDLE;
            end else begin
              state_r <= ST_GRANT;
            end
          end else if (timeout_s) begin
            burst_cnt_r <= burst_next_s;
            state_r     <= ST_GRANT;
          end
        end
        default: begin
          bgnt_r  <= 2'b00;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave-side drive: live owner request in GRANT, latched copy in BUSY.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wr    = 1'b0;
    s_tsize = 2'd0;
    case (state_r)
      ST_GRANT: begin
        s_addr  = own_addr_s;
        s_wdata = own_wdata_s;
        s_wr    = own_wr_s;
        s_tsize = own_tsize_s;
      end
      ST_BUSY: begin
        s_addr  = lat_addr_r;
        s_wdata = lat_wdata_r;
        s_wr    = lat_wr_r;
        s_tsize = lat_tsize_r;
      end
      default: begin
        s_addr  = '0;
        s_wdata = '0;
        s_wr    = 1'b0;
        s_tsize = 2'd0;
      end
    endcase
  end

  // Master-side responses: completion and read data pass through the same cycle.
  always_comb begin
    m0_bdone  = done_s && !owner_r;
    m1_bdone  = done_s && owner_r;
    m0_berror = miss_err_r[0] || (timeout_s && !owner_r);
    m1_berror = miss_err_r[1] || (timeout_s && owner_r);
    if (done_s && !owner_r) begin
      m0_rdata = s_rdata;
    end else begin
      m0_rdata = '0;
    end
    if (done_s && owner_r) begin
      m1_rdata = s_rdata;
    end else begin
      m1_rdata = '0;
    end
  end

  assign s_ss     = (state_r == ST_BUSY) || start_hit_s;
  assign s_bstart = start_hit_s;
  assign m0_bgnt  = bgnt_r[0];
  assign m1_bgnt  = bgnt_r[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MAX_BURST = 4,
// TIMEOUT_CYC = 8). Inputs change 2 time units after the rising edge and
// outputs are sampled 1 unit later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_breq, m0_bgnt, m0_bstart, m0_wr, m0_bdone, m0_berror;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_tsize;
  logic        m1_breq, m1_bgnt, m1_bstart, m1_wr, m1_bdone, m1_berror;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_tsize;
  logic        s_ss, s_bstart, s_wr, s_bdone;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_tsize;

  int tests_run;
  int tests_failed;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .REGION(4'hF), .MAX_BURST(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(m0_breq), .m0_bgnt(m0_bgnt), .m0_bstart(m0_bstart), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wr(m0_wr), .m0_tsize(m0_tsize), .m0_rdata(m0_rdata),
    .m0_bdone(m0_bdone), .m0_berror(m0_berror),
    .m1_breq(m1_breq), .m1_bgnt(m1_bgnt), .m1_bstart(m1_bstart), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wr(m1_wr), .m1_tsize(m1_tsize), .m1_rdata(m1_rdata),
    .m1_bdone(m1_bdone), .m1_berror(m1_berror),
    .s_ss(s_ss), .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wr(s_wr), .s_tsize(s_tsize), .s_rdata(s_rdata), .s_bdone(s_bdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs may change right after this returns.
  task automatic step();
    @(posedge clk);
    #2;
    check_eq("bgnt_not_both", {31'd0, m0_bgnt & m1_bgnt}, 32'd0);
  endtask

  task automatic idle_inputs();
    m0_breq = 1'b0; m0_bstart = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wr = 1'b0; m0_tsize = 2'd0;
    m1_breq = 1'b0; m1_bstart = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wr = 1'b0; m1_tsize = 2'd0;
    s_rdata = 32'd0; s_bdone = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    // Reset state
    check_eq("rst_m0_bgnt", {31'd0, m0_bgnt}, 32'd0);
    check_eq("rst_m1_bgnt", {31'd0, m1_bgnt}, 32'd0);
    check_eq("rst_s_ss", {31'd0, s_ss}, 32'd0);
    check_eq("rst_s_addr", s_addr, 32'd0);
    check_eq("rst_berror", {30'd0, m0_berror, m1_berror}, 32'd0);
    rst_n = 1'b1;

    // Single M1 read
    step();
    m1_breq = 1'b1;
    #1 check_eq("t1_gnt_latency", {31'd0, m1_bgnt}, 32'd0);
    step();
    check_eq("t1_m1_bgnt", {31'd0, m1_bgnt}, 32'd1);
    check_eq("t1_m0_bgnt", {31'd0, m0_bgnt}, 32'd0);
    m1_bstart = 1'b1; m1_addr = 32'hF000_0010; m1_wr = 1'b0; m1_tsize = 2'd2;
    #1;
    check_eq("t1_s_ss", {31'd0, s_ss}, 32'd1);
    check_eq("t1_s_bstart", {31'd0, s_bstart}, 32'd1);
    check_eq("t1_s_addr", s_addr, 32'hF000_0010);
    check_eq("t1_s_tsize", {30'd0, s_tsize}, 32'd2);
    step();
    m1_bstart = 1'b0; m1_addr = 32'd0; s_bdone = 1'b1; s_rdata = 32'h0000_1234;
    #1;
    check_eq("t1_busy_ss", {31'd0, s_ss}, 32'd1);
    check_eq("t1_busy_bstart", {31'd0, s_bstart}, 32'd0);
    check_eq("t1_latched_addr", s_addr, 32'hF000_0010);
    check_eq("t1_m1_bdone", {31'd0, m1_bdone}, 32'd1);
    check_eq("t1_m1_rdata", m1_rdata, 32'h0000_1234);
    check_eq("t1_m0_bdone", {31'd0, m0_bdone}, 32'd0);
    step();
    s_bdone = 1'b0; s_rdata = 32'd0; m1_breq = 1'b0;
    #1;
    check_eq("t1_bdone_pulse", {31'd0, m1_bdone}, 32'd0);
    check_eq("t1_ss_drop", {31'd0, s_ss}, 32'd0);
    check_eq("t1_gnt_held", {31'd0, m1_bgnt}, 32'd1);
    step();
    check_eq("t1_release", {31'd0, m1_bgnt}, 32'd0);

    // Simultaneous requests after reset: M0 first, M1 after one idle cycle
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m0_breq = 1'b1; m1_breq = 1'b1;
    step();
    check_eq("t2_m0_first", {31'd0, m0_bgnt}, 32'd1);
    check_eq("t2_m1_waits", {31'd0, m1_bgnt}, 32'd0);
    m0_breq = 1'b0;
    step();
    check_eq("t2_idle_gap", {30'd0, m1_bgnt, m0_bgnt}, 32'd0);
    step();
    check_eq("t2_m1_granted", {30'd0, m1_bgnt, m0_bgnt}, 32'd2);
    m1_breq = 1'b0;
    step();
    check_eq("t2_m1_release", {31'd0, m1_bgnt}, 32'd0);

    // Burst limit: M0 forced off after 4 completions while M1 waits
    m0_breq = 1'b1; m1_breq = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      check_eq("t3_m0_gnt", {30'd0, m1_bgnt, m0_bgnt}, 32'd1);
      m0_bstart = 1'b1; m0_addr = 32'hF000_0100 + 32'(k * 4);
      #1 check_eq("t3_s_bstart", {31'd0, s_bstart}, 32'd1);
      step();
      m0_bstart = 1'b0; s_bdone = 1'b1; s_rdata = 32'hA000_0000 + 32'(k);
      #1;
      check_eq("t3_m0_bdone", {31'd0, m0_bdone}, 32'd1);
      check_eq("t3_m0_rdata", m0_rdata, 32'hA000_0000 + 32'(k));
      check_eq("t3_m1_bdone", {31'd0, m1_bdone}, 32'd0);
      step();
      s_bdone = 1'b0; s_rdata = 32'd0;
    end
    m0_bstart = 1'b1; m0_addr = 32'hF000_0200;
    #1;
    check_eq("t3_forced_idle", {30'd0, m1_bgnt, m0_bgnt}, 32'd0);
    check_eq("t3_idle_bstart", {31'd0, s_bstart}, 32'd0);
    step();
    m1_addr = 32'hF000_0300;
    #1;
    check_eq("t3_m1_granted", {30'd0, m1_bgnt, m0_bgnt}, 32'd2);
    check_eq("t3_nonowner_bstart", {31'd0, s_bstart}, 32'd0);
    check_eq("t3_owner_addr", s_addr, 32'hF000_0300);
    m0_bstart = 1'b0; m0_breq = 1'b0; m1_breq = 1'b0; m1_addr = 32'd0;
    step();
    check_eq("t3_m0_no_err", {31'd0, m0_berror}, 32'd0);
    check_eq("t3_m1_release", {31'd0, m1_bgnt}, 32'd0);

    // Decode miss, s_bdone outside BUSY, then a hit write
    m1_breq = 1'b1;
    step();
    m1_bstart = 1'b1; m1_addr = 32'h8000_0000; m1_wr = 1'b1; m1_wdata = 32'h1111_2222;
    #1;
    check_eq("t4_miss_ss", {31'd0, s_ss}, 32'd0);
    check_eq("t4_miss_bstart", {31'd0, s_bstart}, 32'd0);
    step();
    m1_bstart = 1'b0; s_bdone = 1'b1;
    #1;
    check_eq("t4_berror", {31'd0, m1_berror}, 32'd1);
    check_eq("t4_m0_berror", {31'd0, m0_berror}, 32'd0);
    check_eq("t4_gnt_kept", {31'd0, m1_bgnt}, 32'd1);
    check_eq("t4_stray_bdone", {31'd0, m1_bdone}, 32'd0);
    step();
    s_bdone = 1'b0;
    check_eq("t4_berror_pulse", {31'd0, m1_berror}, 32'd0);
    m1_bstart = 1'b1; m1_addr = 32'hF000_0020; m1_wdata = 32'hCAFE_F00D;
    #1;
    check_eq("t4_hit_bstart", {31'd0, s_bstart}, 32'd1);
    check_eq("t4_s_wr", {31'd0, s_wr}, 32'd1);
    check_eq("t4_s_wdata", s_wdata, 32'hCAFE_F00D);
    step();
    m1_bstart = 1'b0;

    // Silent slave
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) begin
      #1 check_eq("t5_no_early_berror", {31'd0, m1_berror}, 32'd0);
      step();
    end
    #1 check_eq("t5_timeout_berror", {31'd0, m1_berror}, 32'd1);
    step();
    check_eq("t5_ss_drop", {31'd0, s_ss}, 32'd0);
    check_eq("t5_berror_pulse", {31'd0, m1_berror}, 32'd0);
    check_eq("t5_gnt_kept", {31'd0, m1_bgnt}, 32'd1);
`else
    repeat (100) step();
    check_eq("t5_still_busy", {31'd0, s_ss}, 32'd1);
    check_eq("t5_no_berror", {31'd0, m1_berror}, 32'd0);
    check_eq("t5_no_bdone", {31'd0, m1_bdone}, 32'd0);
`endif
    m1_bstart = 1'b1; m1_addr = 32'hF000_0040;
    step();
    m1_bstart = 1'b0;

    // Reset in the middle of a transaction
    #1 check_eq("t6_busy_before", {31'd0, s_ss}, 32'd1);
    rst_n = 1'b0; s_bdone = 1'b1; s_rdata = 32'h0000_0055;
    #1;
    check_eq("t6_rst_ss", {31'd0, s_ss}, 32'd0);
    check_eq("t6_rst_addr", s_addr, 32'd0);
    check_eq("t6_rst_bgnt", {30'd0, m1_bgnt, m0_bgnt}, 32'd0);
    check_eq("t6_rst_bdone", {31'd0, m1_bdone}, 32'd0);
    check_eq("t6_rst_rdata", m1_rdata, 32'd0);
    s_bdone = 1'b0; s_rdata = 32'd0;
    rst_n = 1'b1;
    step();
    check_eq("t6_regrant", {30'd0, m1_bgnt, m0_bgnt}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
